// File: rtl/keypad_scan_pkg.sv
// Shared types, key codes and the (row, col) -> code map for the keypad front end.
// KEYPAD_ALPHA_EN: when defined, column 3 (A..D) is scanned as well.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } keypad_state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;

`ifdef KEYPAD_ALPHA_EN
    localparam int NUM_COLS = 4;
`else
    localparam int NUM_COLS = 3;
`endif

    function automatic logic [3:0] keypad_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

    // True when exactly one row line is pulled low.
    function automatic logic one_low(input logic [3:0] rows);
        return $countones(~rows) == 1;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchroniser for the asynchronous, pulled-up row returns; resets to idle-high.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row debounce, one key_valid pulse per press.
// KEYPAD_ALPHA_EN: when defined, column 3 is scanned and A..D can be reported.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]    COL_LAST   = 2'(NUM_COLS - 1);

    logic [3:0]    rows_s;
    keypad_state_t state_q, state_d;
    logic [1:0]    col_q, col_d, col_adv;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;

    sync2 #(.W(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_n),
        .q_o (rows_s)
    );

    assign col_adv = (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            pat_q   <= 4'hF;
            valid_q <= 1'b0;
            code_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        valid_d = 1'b0;
        code_d  = code_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (one_low(rows_s)) begin
                        pat_d   = rows_s;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_adv;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end

            DEBOUNCE: begin
                if (rows_s == pat_q) begin
                    if (cnt_q == CNT_LAST) begin
                        valid_d = 1'b1;
                        code_d  = keypad_map(low_index(pat_q), col_q);
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    col_d   = col_adv;
                    state_d = SCAN;
                end
            end

            RELEASE: begin
                // Any low row restarts the quiet-time count, so bounces only stretch this state.
                if (rows_s == 4'hF) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        col_d   = col_adv;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = SCAN;
                cnt_d   = '0;
                dwell_d = '0;
            end
        endcase
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule
